// File: rtl/fir_pkg.sv
// Shared sample type and width constant for the FIR filter / decimator chain.
package fir_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;

  typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

  // A counter for M phases needs at least one bit, even when M is 1.
  function automatic int phaseWidth(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with wrapping pointers and an explicit occupancy count.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [AW:0]      level_q, level_d;
  logic             doRd, doWr;

  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LEVEL);
  assign level   = level_q;
  assign rd_data = empty ? '0 : mem_q[rdPtr_q];

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  always_comb begin
    doRd    = rd_en && !empty;
    doWr    = wr_en && (!full || doRd);
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (doWr) wrPtr_d = wrPtr_q + AW'(1);
    if (doRd) rdPtr_d = rdPtr_q + AW'(1);
    if (doWr && !doRd) level_d = level_q + (AW+1)'(1);
    else if (doRd && !doWr) level_d = level_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (doWr) mem_q[wrPtr_q] <= wr_data;
  end

endmodule

// File: rtl/sample_decimator.sv
// Keeps one valid sample in DECIM_FACTOR and buffers the kept samples for a
// ready/valid consumer, flagging any kept sample lost to a full buffer.
module sample_decimator
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int DECIM_FACTOR = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [DATA_WIDTH-1:0]  x,
  input  logic                          x_valid,
  output logic signed [DATA_WIDTH-1:0]  y,
  output logic                          y_valid,
  input  logic                          y_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int PHASE_W = phaseWidth(DECIM_FACTOR);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(DECIM_FACTOR - 1);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               overflow_q, overflow_d;
  logic               keep, pop, push;
  logic               fifoEmpty, fifoFull;
  logic [DATA_WIDTH-1:0] fifoRdData;

  assign y_valid  = !fifoEmpty;
  assign y        = fifoRdData;
  assign overflow = overflow_q;

  // A kept sample that meets a full buffer is dropped unless the head pops now.
  always_comb begin
    keep       = x_valid && (phase_q == '0);
    pop        = y_valid && y_ready;
    push       = keep && (!fifoFull || pop);
    overflow_d = overflow_q | (keep && fifoFull && !pop);
    phase_d    = phase_q;
    if (x_valid) phase_d = (phase_q == LAST_PHASE) ? '0 : phase_q + PHASE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push),
    .wr_data (x),
    .rd_en   (pop),
    .rd_data (fifoRdData),
    .empty   (fifoEmpty),
    .full    (fifoFull),
    .level   (level)
  );

endmodule

// File: tb/tb_sample_decimator.sv
// Drives three decimator configurations (M=4, M=1, M=3; depth 8) from shared inputs
// and checks each scenario against directed expectations or a queue-based model.
module tb_sample_decimator;
  import fir_pkg::*;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  sample_t x = '0;
  logic    xValid = 1'b0;
  logic    yReady = 1'b0;

  sample_t y4, y1, y3;
  logic    yv4, yv1, yv3;
  logic [3:0] lvl4, lvl1, lvl3;
  logic    ovf4, ovf1, ovf3;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sample_decimator #(.DATA_WIDTH(16), .DECIM_FACTOR(4), .FIFO_DEPTH(8)) dut4 (
    .clk(clk), .reset(reset), .x(x), .x_valid(xValid), .y(y4), .y_valid(yv4),
    .y_ready(yReady), .level(lvl4), .overflow(ovf4));

  sample_decimator #(.DATA_WIDTH(16), .DECIM_FACTOR(1), .FIFO_DEPTH(8)) dut1 (
    .clk(clk), .reset(reset), .x(x), .x_valid(xValid), .y(y1), .y_valid(yv1),
    .y_ready(yReady), .level(lvl1), .overflow(ovf1));

  sample_decimator #(.DATA_WIDTH(16), .DECIM_FACTOR(3), .FIFO_DEPTH(8)) dut3 (
    .clk(clk), .reset(reset), .x(x), .x_valid(xValid), .y(y3), .y_valid(yv3),
    .y_ready(yReady), .level(lvl3), .overflow(ovf3));

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; xValid = 1'b0; yReady = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; yReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x = sample_t'($urandom()); xValid = 1'b1;
    end
    @(negedge clk);
    vectors++; if ({yv4, yv1, yv3} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_y_valid: got %b expected 000", {yv4, yv1, yv3}); end
    vectors++; if ({y4, y1, y3} !== 48'd0) begin miscompares++; $display("[TB] FAIL reset_y: got %h expected 0", {y4, y1, y3}); end
    vectors++; if ({lvl4, lvl1, lvl3} !== 12'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %h expected 0", {lvl4, lvl1, lvl3}); end
    vectors++; if ({ovf4, ovf1, ovf3} !== 3'b000) begin miscompares++; $display("[TB] FAIL reset_overflow: got %b expected 000", {ovf4, ovf1, ovf3}); end
    reset = 1'b0; xValid = 1'b0; yReady = 1'b0;
  endtask

  task automatic test_stream();
    logic    expV;
    sample_t expY;
    doReset();
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      expV = (k > 0) && (((k - 1) % 4) == 0);
      expY = expV ? sample_t'(k - 1) : sample_t'(0);
      vectors++; if (yv4 !== expV) begin miscompares++; $display("[TB] FAIL stream_y_valid k=%0d: got %b expected %b", k, yv4, expV); end
      vectors++; if (y4 !== expY) begin miscompares++; $display("[TB] FAIL stream_y k=%0d: got %0d expected %0d", k, y4, expY); end
      vectors++; if (lvl4 !== {3'b000, expV}) begin miscompares++; $display("[TB] FAIL stream_level k=%0d: got %0d expected %0d", k, lvl4, expV); end
      yReady = 1'b1;
      if (k < 16) begin x = sample_t'(k); xValid = 1'b1; end
      else xValid = 1'b0;
    end
    xValid = 1'b0;
  endtask

  task automatic test_toggle();
    sample_t got4[$], got3[$], got1[$];
    int exp4[$] = '{10, 14, 18};
    int exp3[$] = '{10, 13, 16, 19};
    doReset();
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      if (yv4) got4.push_back(y4);
      if (yv3) got3.push_back(y3);
      if (yv1) got1.push_back(y1);
      yReady = 1'b1;
      xValid = (c < 24) && ((c % 2) == 0);
      if (xValid) x = sample_t'(10 + c / 2);
    end
    xValid = 1'b0;
    vectors++; if (got4.size() != exp4.size()) begin miscompares++; $display("[TB] FAIL toggle_m4_count: got %0d expected %0d", got4.size(), exp4.size()); end
    for (int i = 0; i < exp4.size(); i++) begin
      vectors++; if (i >= got4.size() || got4[i] !== sample_t'(exp4[i])) begin miscompares++; $display("[TB] FAIL toggle_m4_sample %0d: got %0d expected %0d", i, (i < got4.size()) ? int'(got4[i]) : -1, exp4[i]); end
    end
    vectors++; if (got3.size() != exp3.size()) begin miscompares++; $display("[TB] FAIL toggle_m3_count: got %0d expected %0d", got3.size(), exp3.size()); end
    for (int i = 0; i < exp3.size(); i++) begin
      vectors++; if (i >= got3.size() || got3[i] !== sample_t'(exp3[i])) begin miscompares++; $display("[TB] FAIL toggle_m3_sample %0d: got %0d expected %0d", i, (i < got3.size()) ? int'(got3[i]) : -1, exp3[i]); end
    end
    vectors++; if (got1.size() != 12) begin miscompares++; $display("[TB] FAIL toggle_m1_count: got %0d expected 12", got1.size()); end
    for (int i = 0; i < 12; i++) begin
      vectors++; if (i >= got1.size() || got1[i] !== sample_t'(10 + i)) begin miscompares++; $display("[TB] FAIL toggle_m1_sample %0d: got %0d expected %0d", i, (i < got1.size()) ? int'(got1[i]) : -1, 10 + i); end
    end
  endtask

  task automatic test_overflow();
    doReset();
    yReady = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 9) begin
        vectors++; if (lvl1 !== 4'd8) begin miscompares++; $display("[TB] FAIL ovf_level_before: got %0d expected 8", lvl1); end
        vectors++; if (ovf1 !== 1'b0) begin miscompares++; $display("[TB] FAIL ovf_flag_before: got %b expected 0", ovf1); end
      end
      x = sample_t'(i); xValid = 1'b1;
    end
    @(negedge clk);
    xValid = 1'b0;
    vectors++; if (lvl1 !== 4'd8) begin miscompares++; $display("[TB] FAIL ovf_level_after: got %0d expected 8", lvl1); end
    vectors++; if (ovf1 !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag_after: got %b expected 1", ovf1); end
    vectors++; if (yv1 !== 1'b1 || y1 !== sample_t'(1)) begin miscompares++; $display("[TB] FAIL ovf_head: got valid=%b y=%0d expected valid=1 y=1", yv1, y1); end
    yReady = 1'b1;
    for (int i = 2; i <= 8; i++) begin
      @(negedge clk);
      vectors++; if (yv1 !== 1'b1 || y1 !== sample_t'(i)) begin miscompares++; $display("[TB] FAIL ovf_drain %0d: got valid=%b y=%0d expected valid=1 y=%0d", i, yv1, y1, i); end
    end
    @(negedge clk);
    vectors++; if (yv1 !== 1'b0 || y1 !== sample_t'(0) || lvl1 !== 4'd0) begin miscompares++; $display("[TB] FAIL ovf_empty: got valid=%b y=%0d level=%0d expected 0 0 0", yv1, y1, lvl1); end
    vectors++; if (ovf1 !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky: got %b expected 1", ovf1); end
    yReady = 1'b0;
  endtask

  task automatic test_full_push_pop();
    doReset();
    yReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      x = sample_t'(101 + i); xValid = 1'b1;
    end
    @(negedge clk);
    vectors++; if (lvl1 !== 4'd8 || y1 !== sample_t'(101)) begin miscompares++; $display("[TB] FAIL full_fill: got level=%0d y=%0d expected 8 101", lvl1, y1); end
    x = sample_t'(109); xValid = 1'b1; yReady = 1'b1;
    @(negedge clk);
    xValid = 1'b0;
    vectors++; if (lvl1 !== 4'd8) begin miscompares++; $display("[TB] FAIL full_pushpop_level: got %0d expected 8", lvl1); end
    vectors++; if (ovf1 !== 1'b0) begin miscompares++; $display("[TB] FAIL full_pushpop_overflow: got %b expected 0", ovf1); end
    for (int j = 0; j < 8; j++) begin
      if (j > 0) @(negedge clk);
      vectors++; if (yv1 !== 1'b1 || y1 !== sample_t'(102 + j)) begin miscompares++; $display("[TB] FAIL full_order %0d: got valid=%b y=%0d expected %0d", j, yv1, y1, 102 + j); end
    end
    @(negedge clk);
    vectors++; if (yv1 !== 1'b0) begin miscompares++; $display("[TB] FAIL full_drained: got %b expected 0", yv1); end
    yReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    doReset();
    yReady = 1'b0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      x = sample_t'($urandom()); xValid = 1'b1;
    end
    @(negedge clk);
    vectors++; if (lvl4 !== 4'd5) begin miscompares++; $display("[TB] FAIL mid_level_before: got %0d expected 5", lvl4); end
    vectors++; if (ovf1 !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_m1_overflow_before: got %b expected 1", ovf1); end
    reset = 1'b1; xValid = 1'b1; x = sample_t'($urandom());
    @(negedge clk);
    reset = 1'b0; xValid = 1'b1; x = sample_t'(16'sh8000);
    vectors++; if (yv4 !== 1'b0 || y4 !== sample_t'(0)) begin miscompares++; $display("[TB] FAIL mid_cleared_output: got valid=%b y=%0d expected 0 0", yv4, y4); end
    vectors++; if (lvl4 !== 4'd0 || ovf4 !== 1'b0 || ovf1 !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_cleared_state: got level=%0d ovf4=%b ovf1=%b expected 0 0 0", lvl4, ovf4, ovf1); end
    @(negedge clk);
    xValid = 1'b0;
    vectors++; if (yv4 !== 1'b1 || y4 !== sample_t'(16'sh8000) || lvl4 !== 4'd1) begin miscompares++; $display("[TB] FAIL mid_first_kept: got valid=%b y=%0d level=%0d expected 1 -32768 1", yv4, y4, lvl4); end
  endtask

  task automatic test_random();
    sample_t modelQ[$];
    logic    modelOvf = 1'b0;
    int      validCount = 0;
    int      applied = 0;
    int      cycles = 0;
    logic    doPop, doKeep;
    doReset();
    while (applied < 5000 && cycles < 20000) begin
      @(negedge clk);
      cycles++;
      vectors++; if (yv3 !== (modelQ.size() > 0)) begin miscompares++; $display("[TB] FAIL rand_y_valid cyc=%0d: got %b expected %b", cycles, yv3, modelQ.size() > 0); end
      vectors++; if (y3 !== ((modelQ.size() > 0) ? modelQ[0] : sample_t'(0))) begin miscompares++; $display("[TB] FAIL rand_y cyc=%0d: got %0d expected %0d", cycles, y3, (modelQ.size() > 0) ? modelQ[0] : sample_t'(0)); end
      vectors++; if (int'(lvl3) != modelQ.size()) begin miscompares++; $display("[TB] FAIL rand_level cyc=%0d: got %0d expected %0d", cycles, lvl3, modelQ.size()); end
      vectors++; if (ovf3 !== modelOvf) begin miscompares++; $display("[TB] FAIL rand_overflow cyc=%0d: got %b expected %b", cycles, ovf3, modelOvf); end
      xValid = ($urandom_range(99) < 70);
      x      = sample_t'($urandom());
      yReady = ($urandom_range(99) < ((applied < 2500) ? 20 : 60));
      doPop  = (modelQ.size() > 0) && yReady;
      doKeep = xValid && ((validCount % 3) == 0);
      if (xValid) begin validCount++; applied++; end
      if (doPop) void'(modelQ.pop_front());
      if (doKeep) begin
        if (modelQ.size() < 8) modelQ.push_back(x);
        else modelOvf = 1'b1;
      end
    end
    @(negedge clk);
    vectors++; if (int'(lvl3) != modelQ.size() || ovf3 !== modelOvf) begin miscompares++; $display("[TB] FAIL rand_final: got level=%0d ovf=%b expected %0d %b", lvl3, ovf3, modelQ.size(), modelOvf); end
    vectors++; if (applied < 5000) begin miscompares++; $display("[TB] FAIL rand_budget: got %0d samples expected 5000", applied); end
    xValid = 1'b0; yReady = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_toggle();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
